// File: rtl/fpm_round_pack.sv
// fpm_round_pack: final multiplier stage; CSA add, normalize,
// round-to-nearest-even and binary32 pack over three registered stages.
module fpm_round_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        valid_in,
    input  logic [64:0] sum_in,
    input  logic [64:0] carry_in,
    input  logic [74:1] comb_in,
    output logic [31:0] result,
    output logic        valid_out,
    output logic        ovf,
    output logic        unf
);

    // S1 state
    logic [47:0] p_q, p_d;
    logic [8:0]  exp1_q;
    logic        sgn1_q, zero1_q, vld1_q;
    logic        zero_d;

    // S2 state
    logic [22:0]        m2_q, m2_d;
    logic               rnd2_q, rnd2_d;
    logic signed [10:0] e2_q, e2_d;
    logic               sgn2_q, zero2_q, vld2_q;

    // S3 state
    logic [31:0] res_q, res_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;
    logic        vld3_q;

    // Product bits above 47 never reach the result.
    logic unused_hi;
    assign unused_hi = ^{sum_in[64:48], carry_in[64:48]};

    assign p_d    = sum_in[47:0] + carry_in[47:0];
    assign zero_d = (comb_in[32:1] == 32'd0) | (comb_in[64:33] == 32'd0);

    logic norm, g, st;
    always_comb begin
        norm = p_q[47];
        if (norm) begin
            m2_d = p_q[46:24];
            g    = p_q[23];
            st   = |p_q[22:0];
        end else begin
            m2_d = p_q[45:23];
            g    = p_q[22];
            st   = |p_q[21:0];
        end
        rnd2_d = g & (st | m2_d[0]);
        e2_d   = $signed({2'b00, exp1_q}) - 11'sd127
               + $signed({10'd0, norm});
    end

    logic [23:0]        msum;
    logic [22:0]        mr;
    logic signed [10:0] ef;
    always_comb begin
        msum = {1'b0, m2_q} + {23'd0, rnd2_q};
        // A rounding carry makes the mantissa 1.0 at the next exponent.
        mr   = msum[23] ? 23'd0 : msum[22:0];
        ef   = e2_q + $signed({10'd0, msum[23]});
        res_d = {sgn2_q, ef[7:0], mr};
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (zero2_q) begin
            res_d = {sgn2_q, 31'd0};
        end else if (ef >= 11'sd255) begin
            res_d = {sgn2_q, 8'hFF, 23'd0};
            ovf_d = 1'b1;
        end else if (ef <= 11'sd0) begin
            res_d = {sgn2_q, 31'd0};
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q     <= '0;
            exp1_q  <= '0;
            sgn1_q  <= 1'b0;
            zero1_q <= 1'b0;
            vld1_q  <= 1'b0;
            m2_q    <= '0;
            rnd2_q  <= 1'b0;
            e2_q    <= '0;
            sgn2_q  <= 1'b0;
            zero2_q <= 1'b0;
            vld2_q  <= 1'b0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            vld3_q  <= 1'b0;
        end else if (en) begin
            p_q     <= p_d;
            exp1_q  <= comb_in[73:65];
            sgn1_q  <= comb_in[74];
            zero1_q <= zero_d;
            vld1_q  <= valid_in;
            m2_q    <= m2_d;
            rnd2_q  <= rnd2_d;
            e2_q    <= e2_d;
            sgn2_q  <= sgn1_q;
            zero2_q <= zero1_q;
            vld2_q  <= vld1_q;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            vld3_q  <= vld2_q;
        end
    end

    assign result    = res_q;
    assign valid_out = vld3_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

endmodule
